// File: rtl/tdma_nd_midend.sv
// tdma_nd_midend
// Takes one N-dimensional transfer descriptor and turns it into a stream of
// 1-D burst requests (src, dst, len) for the iDMA backend. Dimension 0 is the
// fastest-moving outer dimension. The innermost dimension is the contiguous
// byte length nd_len_i.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   nd_valid_i / nd_ready_o  descriptor handshake; ready only while idle
//   nd_src_addr_i            source base address
//   nd_dst_addr_i            destination base address
//   nd_len_i                 bytes per burst
//   nd_reps_i                per-dimension repetition counts (slice d = dim d)
//   nd_src_stride_i          per-dimension signed source strides
//   nd_dst_stride_i          per-dimension signed destination strides
//   burst_valid_o/ready_i    burst handshake towards the backend
//   burst_src_addr_o         burst source address
//   burst_dst_addr_o         burst destination address
//   burst_len_o              burst byte length
//   busy_o                   descriptor in flight
//   done_o                   one-cycle pulse in the first idle cycle after a descriptor
//
// state | meaning
// IDLE  | waiting for a descriptor, nd_ready_o high
// RUN   | presenting bursts, one per handshake
// ZERO  | empty descriptor (len or some reps is 0), one cycle, no bursts

module tdma_nd_midend #(
    parameter int unsigned NumDim      = 4,
    parameter int unsigned AddrWidth   = 64,
    parameter int unsigned LenWidth    = 32,
    parameter int unsigned RepWidth    = 32,
    parameter int unsigned StrideWidth = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          nd_valid_i,
    output logic                          nd_ready_o,
    input  logic [AddrWidth-1:0]          nd_src_addr_i,
    input  logic [AddrWidth-1:0]          nd_dst_addr_i,
    input  logic [LenWidth-1:0]           nd_len_i,
    input  logic [NumDim*RepWidth-1:0]    nd_reps_i,
    input  logic [NumDim*StrideWidth-1:0] nd_src_stride_i,
    input  logic [NumDim*StrideWidth-1:0] nd_dst_stride_i,
    output logic                          burst_valid_o,
    input  logic                          burst_ready_i,
    output logic [AddrWidth-1:0]          burst_src_addr_o,
    output logic [AddrWidth-1:0]          burst_dst_addr_o,
    output logic [LenWidth-1:0]           burst_len_o,
    output logic                          busy_o,
    output logic                          done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ZERO = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [LenWidth-1:0]  len_q;
    logic [RepWidth-1:0]  reps_q       [NumDim];
    logic [AddrWidth-1:0] src_stride_q [NumDim];
    logic [AddrWidth-1:0] dst_stride_q [NumDim];
    logic [RepWidth-1:0]  cnt_q        [NumDim];
    logic [RepWidth-1:0]  cnt_d        [NumDim];

    // pos_q[d] is the current address with all dimensions below d rewound to 0.
    // pos_q[0] is therefore the address of the burst being presented.
    logic [AddrWidth-1:0] src_pos_q    [NumDim];
    logic [AddrWidth-1:0] src_pos_d    [NumDim];
    logic [AddrWidth-1:0] dst_pos_q    [NumDim];
    logic [AddrWidth-1:0] dst_pos_d    [NumDim];

    logic                 done_q, done_d;
    logic                 accept;
    logic                 advance;
    logic                 desc_zero;
    logic                 last;
    logic [NumDim-1:0]    wrap;
    logic [NumDim:0]      carry;
    logic [AddrWidth-1:0] src_step;
    logic [AddrWidth-1:0] dst_step;

    assign nd_ready_o       = (state_q == IDLE);
    assign burst_valid_o    = (state_q == RUN);
    assign busy_o           = (state_q != IDLE);
    assign done_o           = done_q;
    assign burst_src_addr_o = src_pos_q[0];
    assign burst_dst_addr_o = dst_pos_q[0];
    assign burst_len_o      = len_q;

    assign accept  = (state_q == IDLE) && nd_valid_i;
    assign advance = (state_q == RUN) && burst_ready_i;

    always_comb begin
        desc_zero = (nd_len_i == '0);
        for (int d = 0; d < NumDim; d++) begin
            if (nd_reps_i[d*RepWidth +: RepWidth] == '0) begin
                desc_zero = 1'b1;
            end
        end
    end

    // Odometer: carry ripples through every dimension sitting at its last count.
    always_comb begin
        carry[0] = 1'b1;
        for (int d = 0; d < NumDim; d++) begin
            wrap[d]      = (cnt_q[d] == (reps_q[d] - RepWidth'(1)));
            carry[d+1]   = carry[d] & wrap[d];
        end
        last = carry[NumDim];
    end

    // Exactly one dimension steps (carry in, no wrap); every dimension below it
    // wraps and restarts from the stepped address. Walking from the top down
    // means the stepped address is known before the wrapping dimensions use it.
    always_comb begin
        src_step = '0;
        dst_step = '0;
        for (int d = NumDim - 1; d >= 0; d--) begin
            cnt_d[d]     = cnt_q[d];
            src_pos_d[d] = src_pos_q[d];
            dst_pos_d[d] = dst_pos_q[d];
            if (carry[d]) begin
                if (wrap[d]) begin
                    cnt_d[d]     = '0;
                    src_pos_d[d] = src_step;
                    dst_pos_d[d] = dst_step;
                end else begin
                    cnt_d[d]     = cnt_q[d] + RepWidth'(1);
                    src_pos_d[d] = src_pos_q[d] + src_stride_q[d];
                    dst_pos_d[d] = dst_pos_q[d] + dst_stride_q[d];
                    src_step     = src_pos_d[d];
                    dst_step     = dst_pos_d[d];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (nd_valid_i) begin
                    state_d = desc_zero ? ZERO : RUN;
                end
            end
            RUN: begin
                if (burst_ready_i && last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            ZERO: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            len_q <= '0;
            for (int d = 0; d < NumDim; d++) begin
                reps_q[d]       <= '0;
                src_stride_q[d] <= '0;
                dst_stride_q[d] <= '0;
                cnt_q[d]        <= '0;
                src_pos_q[d]    <= '0;
                dst_pos_q[d]    <= '0;
            end
        end else if (accept) begin
            len_q <= nd_len_i;
            for (int d = 0; d < NumDim; d++) begin
                reps_q[d]       <= nd_reps_i[d*RepWidth +: RepWidth];
                src_stride_q[d] <= AddrWidth'($signed(nd_src_stride_i[d*StrideWidth +: StrideWidth]));
                dst_stride_q[d] <= AddrWidth'($signed(nd_dst_stride_i[d*StrideWidth +: StrideWidth]));
                cnt_q[d]        <= '0;
                src_pos_q[d]    <= nd_src_addr_i;
                dst_pos_q[d]    <= nd_dst_addr_i;
            end
        end else if (advance) begin
            for (int d = 0; d < NumDim; d++) begin
                cnt_q[d]     <= cnt_d[d];
                src_pos_q[d] <= src_pos_d[d];
                dst_pos_q[d] <= dst_pos_d[d];
            end
        end
    end

endmodule

// File: tb/tb_tdma_nd_midend.sv
// tb_tdma_nd_midend
// Directed bench for tdma_nd_midend with default parameters (4 dims, 64-bit
// addresses, 32-bit len/reps/strides). Inputs change 1 time unit after the
// rising edge and outputs are sampled at the same point.

module tb_tdma_nd_midend;

    logic          clk;
    logic          rst_n;
    logic          nd_valid;
    logic          nd_ready;
    logic [63:0]   nd_src;
    logic [63:0]   nd_dst;
    logic [31:0]   nd_len;
    logic [127:0]  nd_reps;
    logic [127:0]  nd_sstr;
    logic [127:0]  nd_dstr;
    logic          burst_valid;
    logic          burst_ready;
    logic [63:0]   burst_src;
    logic [63:0]   burst_dst;
    logic [31:0]   burst_len;
    logic          busy;
    logic          done;

    int checks   = 0;
    int failures = 0;

    tdma_nd_midend dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .nd_valid_i       (nd_valid),
        .nd_ready_o       (nd_ready),
        .nd_src_addr_i    (nd_src),
        .nd_dst_addr_i    (nd_dst),
        .nd_len_i         (nd_len),
        .nd_reps_i        (nd_reps),
        .nd_src_stride_i  (nd_sstr),
        .nd_dst_stride_i  (nd_dstr),
        .burst_valid_o    (burst_valid),
        .burst_ready_i    (burst_ready),
        .burst_src_addr_o (burst_src),
        .burst_dst_addr_o (burst_dst),
        .burst_len_o      (burst_len),
        .busy_o           (busy),
        .done_o           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a descriptor for one edge (caller guarantees IDLE), then
    // scrambles the descriptor inputs so later changes must have no effect.
    task automatic apply_desc(input logic [63:0] s, input logic [63:0] d, input logic [31:0] l,
                              input logic [127:0] r, input logic [127:0] ss, input logic [127:0] ds);
        nd_src   = s;
        nd_dst   = d;
        nd_len   = l;
        nd_reps  = r;
        nd_sstr  = ss;
        nd_dstr  = ds;
        nd_valid = 1'b1;
        step();
        nd_valid = 1'b0;
        nd_src   = 64'hDEAD_BEEF_0BAD_F00D;
        nd_dst   = 64'h1234_5678_9ABC_DEF0;
        nd_len   = 32'h0000_0005;
        nd_reps  = '1;
        nd_sstr  = '1;
        nd_dstr  = '1;
    endtask

    // Runs from the first RUN cycle: bursts must be presented every cycle in the
    // given order; the backend stalls for stall_len cycles on burst stall_at.
    // Returns in the done cycle after checking it.
    task automatic drive_bursts(input string name, input int n,
                                input logic [63:0] es [8], input logic [63:0] ed [8],
                                input logic [31:0] elen, input int stall_at, input int stall_len);
        int got   = 0;
        int stall = 0;
        int cyc   = 0;
        while (got < n && cyc < 64) begin
            burst_ready = !(got == stall_at && stall < stall_len);
            checks++;
            if (burst_valid !== 1'b1) begin
                failures++;
                $display("FAIL %s valid[%0d]: got %b want 1", name, got, burst_valid);
            end else begin
                checks += 4;
                if (burst_src !== es[got]) begin
                    failures++;
                    $display("FAIL %s src[%0d]: got %h want %h", name, got, burst_src, es[got]);
                end
                if (burst_dst !== ed[got]) begin
                    failures++;
                    $display("FAIL %s dst[%0d]: got %h want %h", name, got, burst_dst, ed[got]);
                end
                if (burst_len !== elen) begin
                    failures++;
                    $display("FAIL %s len[%0d]: got %0d want %0d", name, got, burst_len, elen);
                end
                if (busy !== 1'b1 || done !== 1'b0 || nd_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL %s flags[%0d]: busy=%b done=%b ready=%b want 1 0 0",
                             name, got, busy, done, nd_ready);
                end
            end
            if (burst_ready && burst_valid) begin
                got++;
            end else if (!burst_ready) begin
                stall++;
            end
            step();
            cyc++;
        end
        burst_ready = 1'b1;
        checks++;
        if (got != n) begin
            failures++;
            $display("FAIL %s count: got %0d bursts want %0d (cycle budget expired)", name, got, n);
        end
        checks++;
        if (burst_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0 || nd_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s end: valid=%b done=%b busy=%b ready=%b want 0 1 0 1",
                     name, burst_valid, done, busy, nd_ready);
        end
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        nd_valid    = 1'b0;
        burst_ready = 1'b1;
        nd_src      = '0;
        nd_dst      = '0;
        nd_len      = '0;
        nd_reps     = '0;
        nd_sstr     = '0;
        nd_dstr     = '0;
        #3;
        checks++;
        if (burst_valid !== 1'b0 || nd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset flags: valid=%b ready=%b busy=%b done=%b want 0 1 0 0",
                     burst_valid, nd_ready, busy, done);
        end
        checks++;
        if (burst_src !== 64'h0 || burst_dst !== 64'h0 || burst_len !== 32'h0) begin
            failures++;
            $display("FAIL reset outputs: src=%h dst=%h len=%h want 0", burst_src, burst_dst, burst_len);
        end
        step();
        rst_n = 1'b1;
        step();
        step();
        checks++;
        if (burst_valid !== 1'b0 || nd_ready !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL idle hold: valid=%b ready=%b done=%b want 0 1 0", burst_valid, nd_ready, done);
        end
    endtask

    task automatic test_1d();
        logic [63:0] es [8] = '{64'h1000, 0, 0, 0, 0, 0, 0, 0};
        logic [63:0] ed [8] = '{64'h2000, 0, 0, 0, 0, 0, 0, 0};
        apply_desc(64'h1000, 64'h2000, 32'd64, {32'd1, 32'd1, 32'd1, 32'd1}, '0, '0);
        drive_bursts("1d", 1, es, ed, 32'd64, -1, 0);
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL 1d after: done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] es [8] = '{64'h1000, 64'h1100, 64'h1200, 0, 0, 0, 0, 0};
        logic [63:0] ed [8] = '{64'h2000, 64'h2040, 64'h2080, 0, 0, 0, 0, 0};
        logic [63:0] es1 [8] = '{64'h4000, 0, 0, 0, 0, 0, 0, 0};
        logic [63:0] ed1 [8] = '{64'h5000, 0, 0, 0, 0, 0, 0, 0};
        apply_desc(64'h1000, 64'h2000, 32'd16, {32'd1, 32'd1, 32'd1, 32'd3},
                   {32'd0, 32'd0, 32'd0, 32'h100}, {32'd0, 32'd0, 32'd0, 32'h40});
        drive_bursts("2d", 3, es, ed, 32'd16, -1, 0);
        // accepted in the done cycle
        apply_desc(64'h4000, 64'h5000, 32'd32, {32'd1, 32'd1, 32'd1, 32'd1}, '0, '0);
        drive_bursts("b2b", 1, es1, ed1, 32'd32, -1, 0);
        step();
    endtask

    task automatic test_backpressure();
        logic [63:0] es [8] = '{64'h1000, 64'h1100, 64'h1200, 0, 0, 0, 0, 0};
        logic [63:0] ed [8] = '{64'h2000, 64'h2040, 64'h2080, 0, 0, 0, 0, 0};
        apply_desc(64'h1000, 64'h2000, 32'd16, {32'd1, 32'd1, 32'd1, 32'd3},
                   {32'd0, 32'd0, 32'd0, 32'h100}, {32'd0, 32'd0, 32'd0, 32'h40});
        drive_bursts("bp", 3, es, ed, 32'd16, 1, 5);
        step();
        checks++;
        if (burst_valid !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL bp extra: valid=%b done=%b want 0 0", burst_valid, done);
        end
    endtask

    task automatic test_3d_neg();
        logic [63:0] es [8] = '{64'h8000, 64'h8010, 64'h8100, 64'h8110,
                                64'h7000, 64'h7010, 64'h7100, 64'h7110};
        logic [63:0] ed [8] = '{64'h2000, 64'h2001, 64'h2002, 64'h2003,
                                64'h2004, 64'h2005, 64'h2006, 64'h2007};
        apply_desc(64'h8000, 64'h2000, 32'd8, {32'd1, 32'd2, 32'd2, 32'd2},
                   {32'd0, 32'hFFFF_F000, 32'h100, 32'h10}, {32'd0, 32'd4, 32'd2, 32'd1});
        drive_bursts("3d", 8, es, ed, 32'd8, -1, 0);
        step();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL 3d done twice: got %b want 0", done);
        end
    endtask

    task automatic test_wrap();
        logic [63:0] es [8] = '{64'h10, 64'hFFFF_FFFF_FFFF_FFF0, 0, 0, 0, 0, 0, 0};
        logic [63:0] ed [8] = '{64'hFFFF_FFFF_FFFF_FFF0, 64'h10, 0, 0, 0, 0, 0, 0};
        apply_desc(64'h10, 64'hFFFF_FFFF_FFFF_FFF0, 32'd4, {32'd1, 32'd1, 32'd2, 32'd1},
                   {32'd0, 32'd0, 32'hFFFF_FFE0, 32'd0}, {32'd0, 32'd0, 32'h20, 32'd0});
        drive_bursts("wrap", 2, es, ed, 32'd4, -1, 0);
        step();
    endtask

    task automatic test_zero();
        logic [63:0] es [8] = '{64'h1000, 0, 0, 0, 0, 0, 0, 0};
        logic [63:0] ed [8] = '{64'h2000, 0, 0, 0, 0, 0, 0, 0};
        for (int v = 0; v < 2; v++) begin
            if (v == 0) begin
                apply_desc(64'h1000, 64'h2000, 32'd64, {32'd1, 32'd1, 32'd0, 32'd1}, '0, '0);
            end else begin
                apply_desc(64'h1000, 64'h2000, 32'd0, {32'd2, 32'd2, 32'd2, 32'd2}, '0, '0);
            end
            checks++;
            if (burst_valid !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("FAIL zero%0d mid: valid=%b busy=%b done=%b want 0 1 0", v, burst_valid, busy, done);
            end
            step();
            checks++;
            if (burst_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b1 || nd_ready !== 1'b1) begin
                failures++;
                $display("FAIL zero%0d done: valid=%b busy=%b done=%b ready=%b want 0 0 1 1",
                         v, burst_valid, busy, done, nd_ready);
            end
            apply_desc(64'h1000, 64'h2000, 32'd64, {32'd1, 32'd1, 32'd1, 32'd1}, '0, '0);
            drive_bursts("zero_next", 1, es, ed, 32'd64, -1, 0);
            step();
        end
    endtask

    task automatic test_reset_mid_run();
        logic [63:0] es [8] = '{64'h8000, 64'h8010, 64'h8100, 64'h8110,
                                64'h7000, 64'h7010, 64'h7100, 64'h7110};
        logic [63:0] ed [8] = '{64'h2000, 64'h2001, 64'h2002, 64'h2003,
                                64'h2004, 64'h2005, 64'h2006, 64'h2007};
        apply_desc(64'h8000, 64'h2000, 32'd8, {32'd1, 32'd2, 32'd2, 32'd2},
                   {32'd0, 32'hFFFF_F000, 32'h100, 32'h10}, {32'd0, 32'd4, 32'd2, 32'd1});
        step();
        step();
        checks++;
        if (burst_valid !== 1'b1 || burst_src !== 64'h8100) begin
            failures++;
            $display("FAIL rst pre: valid=%b src=%h want 1 8100", burst_valid, burst_src);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (burst_valid !== 1'b0 || busy !== 1'b0 || nd_ready !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL rst async: valid=%b busy=%b ready=%b done=%b want 0 0 1 0",
                     burst_valid, busy, nd_ready, done);
        end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (done !== 1'b0 || burst_valid !== 1'b0) begin
                failures++;
                $display("FAIL rst quiet[%0d]: done=%b valid=%b want 0 0", i, done, burst_valid);
            end
        end
        apply_desc(64'h8000, 64'h2000, 32'd8, {32'd1, 32'd2, 32'd2, 32'd2},
                   {32'd0, 32'hFFFF_F000, 32'h100, 32'h10}, {32'd0, 32'd4, 32'd2, 32'd1});
        drive_bursts("rst_fresh", 8, es, ed, 32'd8, -1, 0);
        step();
    endtask

    initial begin
        test_reset();
        test_1d();
        test_back_to_back();
        test_backpressure();
        test_3d_neg();
        test_wrap();
        test_zero();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tdma_nd_midend.md
Name: tdma_nd_midend

Overview:
- Parametrised N-dimensional tensor DMA midend. Accepts one N-D transfer descriptor via valid/ready and decomposes it into a stream of 1-D burst requests (src, dst, length) for the iDMA backend.
- Generalises the fixed 4-dimension address generator:
  - configurable dimension count and widths;
  - real backpressure on both sides;
  - signed strides;
  - zero-length and zero-repetition handling;
  - a completion pulse.

Parameters:
- NumDim, 4: number of outer (repeated) dimensions, ≥1. The innermost dimension is the contiguous byte length.
- AddrWidth, 64: address width.
- LenWidth, 32: inner byte-length width.
- RepWidth, 32: per-dimension repetition-count width.
- StrideWidth, 32: per-dimension stride width, signed two's complement.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous reset, active-low
- nd_valid_i  in  1  descriptor valid
- nd_ready_o  out  1  descriptor ready; high only in IDLE
- nd_src_addr_i  in  AddrWidth  source base address
- nd_dst_addr_i  in  AddrWidth  destination base address
- nd_len_i  in  LenWidth  contiguous bytes per burst
- nd_reps_i  in  NumDim*RepWidth  repetitions per dimension; slice d = dimension d; d=0 innermost outer dimension
- nd_src_stride_i  in  NumDim*StrideWidth  signed source stride per dimension
- nd_dst_stride_i  in  NumDim*StrideWidth  signed destination stride per dimension
- burst_valid_o  out  1  burst request valid
- burst_ready_i  in  1  backend accepts burst
- burst_src_addr_o  out  AddrWidth  burst source address
- burst_dst_addr_o  out  AddrWidth  burst destination address
- burst_len_o  out  LenWidth  burst byte length
- busy_o  out  1  high while not IDLE
- done_o  out  1  one-cycle pulse at end of descriptor

Behaviour:
- Reset (asynchronous, any state, including mid-transfer):
  - state = IDLE; all counters, latched descriptor fields and burst outputs = 0.
  - burst_valid_o=0, done_o=0, busy_o=0, nd_ready_o=1.
  - Pending bursts are dropped.
- States:
  - IDLE: nd_ready_o=1.
  - On nd_valid_i & nd_ready_o: latch all descriptor fields and clear counters cnt[d]=0.
    - If nd_len_i==0 or any nd_reps_i[d]==0: go to ZERO.
    - Otherwise go to RUN.
  - RUN:
    - burst_valid_o=1.
    - burst_src_addr_o = src_base + Σ_d cnt[d]*sext(src_stride[d]), modulo 2^AddrWidth. Same formula for dst.
    - burst_len_o = latched len.
    - Incremental per-dimension base registers are the intended implementation. No combinational path from the nd_* inputs to the burst_* outputs.
  - On burst_valid_o & burst_ready_i:
    - Odometer increment: cnt[0]++. If cnt[d]+1 == reps[d], set cnt[d]=0 and carry to d+1.
    - If the handshake was the last burst (all cnt[d] == reps[d]-1), go to IDLE and assert done_o in the next cycle.
  - ZERO: lasts one cycle, then IDLE with done_o asserted in the following cycle. No bursts are issued.
- Latency:
  - First burst_valid_o is asserted in the cycle after descriptor acceptance.
  - Each subsequent burst is presented in the cycle after the previous handshake. Full throughput is 1 burst/cycle when burst_ready_i is held high.
- Handshake rules:
  - While burst_valid_o & !burst_ready_i, all burst_* outputs hold stable.
  - burst_valid_o never drops without a handshake, except on reset.
- done_o:
  - High for exactly one cycle, coinciding with the first IDLE cycle.
  - A new descriptor may be accepted in that same cycle (back-to-back).
- Burst count per descriptor = Π reps[d]. reps[d]=1 means dimension d is unused.
- Arithmetic:
  - Strides are sign-extended to AddrWidth.
  - Address wrap-around at 2^AddrWidth is silent.
  - cnt[d] is RepWidth wide and never exceeds reps[d]-1.
- Descriptor inputs are ignored outside the IDLE handshake. Changing them mid-RUN has no effect.
- busy_o is asserted from the cycle after acceptance up to and including the last RUN/ZERO cycle.

Test Plan:
1. 1-D transfer: src=0x1000, dst=0x2000, len=64, all reps=1, burst_ready_i=1 -> exactly one burst (0x1000, 0x2000, 64) one cycle after accept; done_o pulse in the next cycle; busy_o high for 1 cycle.
2. 2-D transfer: len=16, reps0=3, src_stride0=0x100, dst_stride0=0x40 -> bursts src 0x1000/0x1100/0x1200 and dst 0x2000/0x2040/0x2080 on consecutive cycles; done_o one cycle after the third handshake.
3. Backpressure: scenario 2 with burst_ready_i low for 5 cycles on the second burst -> burst_valid_o stays high and outputs hold 0x1100/0x2040 for all 5 cycles; total burst count stays 3.
4. 3-D carry with negative stride: reps={2,2,2,1}, src_strides={0x10,0x100,-0x1000}, src=0x8000 -> 8 src addresses in order 0x8000, 0x8010, 0x8100, 0x8110, 0x7000, 0x7010, 0x7100, 0x7110; done_o once.
5. Zero transfer: reps1=0 (or len=0) -> no burst_valid_o; done_o pulse 2 cycles after accept; the next descriptor is accepted in the done_o cycle and runs normally.
6. Reset mid-RUN: assert rst_ni=0 after 2 of 8 bursts -> burst_valid_o=0, busy_o=0, nd_ready_o=1 immediately; no done_o; a fresh descriptor after reset starts at cnt=0.
